// File: rtl/spi_request_arbiter.sv
// Round-robin arbiter sharing one SPI configuration controller between N_REQ requesters.
// Issues a one-cycle strobe, tracks spi_busy to completion and returns done/err/rdata to the owner.
module spi_request_arbiter #(
  parameter int N_REQ        = 2,
  parameter int BUSY_TIMEOUT = 64
) (
  input  logic                  sys_clk,
  input  logic                  reset_n,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [2*N_REQ-1:0]    req_kind,
  input  logic [11*N_REQ-1:0]   req_addr,
  input  logic [12*N_REQ-1:0]   req_data,
  output logic [N_REQ-1:0]      grant,
  output logic [N_REQ-1:0]      done,
  output logic                  err,
  output logic [7:0]            rdata,
  output logic                  dac_request_write,
  output logic                  adc_request_write,
  output logic                  adc_request_read,
  output logic [4:0]            dac_address,
  output logic [11:0]           dac_data,
  output logic [10:0]           adc_address,
  output logic [7:0]            adc_data,
  input  logic                  spi_busy,
  input  logic [7:0]            spi_rdata
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(BUSY_TIMEOUT + 1);

  localparam logic [1:0] KIND_DAC_WR  = 2'd0;
  localparam logic [1:0] KIND_ADC_WR  = 2'd1;
  localparam logic [1:0] KIND_ADC_RD  = 2'd2;
  localparam logic [1:0] KIND_ILLEGAL = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_ISSUE      = 3'd1,
    S_WAIT_START = 3'd2,
    S_WAIT_END   = 3'd3,
    S_DONE       = 3'd4
  } state_t;

  state_t            state_r, state_s;
  logic [PW-1:0]     ptr_r, ptr_s;
  logic [1:0]        kind_r, kind_s;
  logic [CW-1:0]     cnt_r, cnt_s;

  logic              found_s;
  logic [PW-1:0]     winner_s;
  int                idx_s;
  logic [1:0]        win_kind_s;
  logic [10:0]       win_addr_s;
  logic [11:0]       win_data_s;

  logic [N_REQ-1:0]  grant_s, done_s;
  logic              err_s, dac_wr_s, adc_wr_s, adc_rd_s;
  logic [7:0]        rdata_s, adc_data_s;
  logic [4:0]        dac_addr_s;
  logic [11:0]       dac_data_s;
  logic [10:0]       adc_addr_s;

  // Round-robin search: first valid requester at or after ptr, wrapping.
  always_comb begin
    found_s  = 1'b0;
    winner_s = '0;
    idx_s    = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx_s = int'(ptr_r) + k;
      if (idx_s >= N_REQ) begin
        idx_s = idx_s - N_REQ;
      end else begin
        idx_s = idx_s;
      end
      if (!found_s && req_valid[idx_s]) begin
        found_s  = 1'b1;
        winner_s = PW'(idx_s);
      end else begin
        found_s  = found_s;
      end
    end
    win_kind_s = req_kind[2*int'(winner_s) +: 2];
    win_addr_s = req_addr[11*int'(winner_s) +: 11];
    win_data_s = req_data[12*int'(winner_s) +: 12];
  end

  // Next-state and next-output logic; every output is registered from these values.
  always_comb begin
    state_s    = state_r;
    ptr_s      = ptr_r;
    kind_s     = kind_r;
    cnt_s      = cnt_r;
    grant_s    = grant;
    done_s     = '0;
    err_s      = err;
    rdata_s    = rdata;
    dac_wr_s   = 1'b0;
    adc_wr_s   = 1'b0;
    adc_rd_s   = 1'b0;
    dac_addr_s = dac_address;
    dac_data_s = dac_data;
    adc_addr_s = adc_address;
    adc_data_s = adc_data;
    case (state_r)
      S_IDLE: begin
        // A busy controller is owned by someone else, so arbitration waits.
        if (found_s && !spi_busy) begin
          state_s           = S_ISSUE;
          kind_s            = win_kind_s;
          grant_s           = '0;
          grant_s[winner_s] = 1'b1;
          ptr_s             = (winner_s == PW'(N_REQ - 1)) ? '0 : winner_s + PW'(1);
          dac_addr_s        = win_addr_s[4:0];
          dac_data_s        = win_data_s;
          adc_addr_s        = win_addr_s;
          adc_data_s        = win_data_s[7:0];
          case (win_kind_s)
            KIND_DAC_WR: dac_wr_s = 1'b1;
            KIND_ADC_WR: adc_wr_s = 1'b1;
            KIND_ADC_RD: adc_rd_s = 1'b1;
            default:     dac_wr_s = 1'b0;
          endcase
        end else begin
          state_s = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (kind_r == KIND_ILLEGAL) begin
          state_s = S_DONE;
          err_s   = 1'b1;
          done_s  = grant;
        end else begin
          state_s = S_WAIT_START;
          cnt_s   = '0;
        end
      end
      S_WAIT_START: begin
        if (spi_busy) begin
          state_s = S_WAIT_END;
        end else if (cnt_r == CW'(BUSY_TIMEOUT)) begin
          state_s = S_DONE;
          err_s   = 1'b1;
          done_s  = grant;
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      S_WAIT_END: begin
        if (!spi_busy) begin
          state_s = S_DONE;
          err_s   = 1'b0;
          done_s  = grant;
          if (kind_r == KIND_ADC_RD) begin
            rdata_s = spi_rdata;
          end else begin
            rdata_s = rdata;
          end
        end else begin
          state_s = S_WAIT_END;
        end
      end
      S_DONE: begin
        state_s = S_IDLE;
        grant_s = '0;
      end
      default: begin
        state_s = S_IDLE;
        grant_s = '0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge sys_clk) begin
    if (!reset_n) begin
      state_r           <= S_IDLE;
      ptr_r             <= '0;
      kind_r            <= 2'd0;
      cnt_r             <= '0;
      grant             <= '0;
      done              <= '0;
      err               <= 1'b0;
      rdata             <= 8'h00;
      dac_request_write <= 1'b0;
      adc_request_write <= 1'b0;
      adc_request_read  <= 1'b0;
      dac_address       <= 5'd0;
      dac_data          <= 12'd0;
      adc_address       <= 11'd0;
      adc_data          <= 8'd0;
    end else begin
      state_r           <= state_s;
      ptr_r             <= ptr_s;
      kind_r            <= kind_s;
      cnt_r             <= cnt_s;
      grant             <= grant_s;
      done              <= done_s;
      err               <= err_s;
      rdata             <= rdata_s;
      dac_request_write <= dac_wr_s;
      adc_request_write <= adc_wr_s;
      adc_request_read  <= adc_rd_s;
      dac_address       <= dac_addr_s;
      dac_data          <= dac_data_s;
      adc_address       <= adc_addr_s;
      adc_data          <= adc_data_s;
    end
  end

endmodule

// File: doc/spi_request_arbiter.md
# spi_request_arbiter

Shares the single SPI configuration controller between several requesters, e.g. the control unit and an automatic ADC/DAC configuration sequencer. Each requester presents a DAC write, ADC register write or ADC register read. The arbiter picks one requester by round-robin and drives the SPI controller's request strobes for one cycle. It then tracks the controller's busy flag through to completion and returns a per-requester done pulse with readback data and an error flag. It sits between the requesters and the SPI controller in the sys_clk domain.

## Interface
- N_REQ, 2: number of requesters (2–8).
- BUSY_TIMEOUT, 64: cycles allowed between the issue strobe and busy rising.
- sys_clk  in  1  system clock; all logic is on the rising edge.
- reset_n  in  1  synchronous reset, active low.
- req_valid  in  N_REQ  requester i holds its request until it sees done[i].
- req_kind  in  2*N_REQ  per requester: 0 = DAC write, 1 = ADC write, 2 = ADC read, 3 = illegal.
- req_addr  in  11*N_REQ  per requester: DAC uses bits [4:0]; ADC uses [10:0].
- req_data  in  12*N_REQ  per requester: DAC uses [11:0]; ADC write uses [7:0].
- grant  out  N_REQ  one-hot owner of the in-flight transaction.
- done  out  N_REQ  one-cycle completion pulse to the owner.
- err  out  1  qualified by done: 1 = timeout or illegal kind.
- rdata  out  8  ADC read result, valid with done.
- dac_request_write, adc_request_write, adc_request_read  out  1 each  one-cycle strobes to the SPI controller.
- dac_address  out  5  SPI controller DAC address.
- dac_data  out  12  SPI controller DAC data.
- adc_address  out  11  SPI controller ADC address.
- adc_data  out  8  SPI controller ADC data.
- spi_busy  in  1  SPI controller busy flag.
- spi_rdata  in  8  SPI controller read result, valid once busy falls after a read.

## Operation
- States:
  - IDLE: wait for any req_valid bit.
  - ISSUE: drive the strobe for one cycle.
  - WAIT_START: wait for spi_busy = 1, counting cycles.
  - WAIT_END: wait for spi_busy = 0.
  - DONE: pulse done for one cycle.
- IDLE → ISSUE:
  - Taken when any req_valid bit is set and spi_busy = 0.
  - The winner is the first set bit at or after the pointer ptr, searching upward with wrap from N_REQ-1 to 0.
  - Latch the winner's kind, address and data into registers. Set grant.
  - Update ptr to winner+1, wrapping at N_REQ.
- IDLE stall: if any req_valid bit is set while spi_busy = 1 (controller owned by something else), stay in IDLE.
- ISSUE:
  - Assert exactly one strobe, selected by the latched kind, with the latched address and data.
  - Address and data outputs hold their latched values until the next ISSUE.
  - Illegal kind (3): no strobe; go directly to DONE with err = 1.
  - Otherwise go to WAIT_START and clear the timeout counter.
- WAIT_START:
  - spi_busy = 1 → WAIT_END.
  - Counter reaches BUSY_TIMEOUT → DONE with err = 1.
- WAIT_END: spi_busy = 0 → DONE. If the kind is ADC read, capture spi_rdata into rdata on the same edge.
- DONE: done[owner] = 1, then return to IDLE. grant clears on entry to IDLE.
- Dropped request: deasserting req_valid of the owner mid-transaction has no effect. The transaction completes and done still pulses.
- New requests: requests arriving during a transaction wait. No requester is granted twice while another requester stays asserted.
- rdata holds its value until the next ADC read completes. err holds until the next DONE.
- Reset (reset_n = 0 at an edge), from any state:
  - State → IDLE; ptr → 0.
  - grant, done and all strobes → 0.
  - err → 0; rdata → 0x00.
  - dac_address, dac_data, adc_address and adc_data → 0.
  - Counter → 0.
- Reset mid-transaction abandons the SPI transfer without a done pulse.

## Timing
- Latency from req_valid rising in IDLE (controller idle) to the strobe: 1 cycle. The strobe is high during the cycle after the arbitration edge.
- Minimum issue-to-done latency with a busy pulse of B cycles: busy is seen at cycle ≥ +1, and done occurs 1 cycle after busy falls.
- Back-to-back operation: one IDLE cycle minimum between DONE and the next ISSUE, so the per-transaction overhead is 3 cycles plus SPI time.
- Timeout: done and err both assert on cycle BUSY_TIMEOUT+2 after the ISSUE cycle.
- All outputs are registered. There are no combinational paths from requester or SPI inputs to outputs.

## Test plan
- Single DAC write, requester 0 (kind 0, addr 0x13, data 0xABC), spi_busy model holds high for 10 cycles → dac_request_write pulses once with dac_address 0x13 and dac_data 0xABC; done[0] fires 1 cycle after busy falls; err = 0.
- ADC read, requester 1 (addr 0x0FF), spi_rdata = 0x5A at busy fall → adc_request_read pulses once; done[1] fires with rdata = 0x5A; rdata still reads 0x5A 20 cycles later.
- Both requesters held valid continuously for 6 transactions from reset → grant sequence is 0,1,0,1,0,1; exactly one strobe per transaction.
- SPI model never raises busy → done and err = 1 at cycle 66 after ISSUE (default BUSY_TIMEOUT = 64); the next request is served normally.
- Illegal kind 3 → no strobe; done pulses with err = 1 two cycles after the request is accepted.
- reset_n dropped during WAIT_END → next edge: grant = 0, state IDLE, no done pulse; after release, a new request gets grant[0] first.
